gpu_tensor_serial_unit: RTL and testbench

//  Responder side of the core's tensor-issue interface (in_valid/in_op/in_a/in_b/in_c -> out_valid/out_y).

---
 rtl/gpu_tensor_pkg.sv | 34 +++
 rtl/gpu_tensor_serial_unit_if.sv | 25 ++
 rtl/gpu_tensor_lane_mul.sv | 33 +++
 rtl/gpu_tensor_serial_unit.sv | 151 +++++++++++++++
 tb/tb_gpu_tensor_serial_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/gpu_tensor_pkg.sv
// Shared definitions for the tensor serial unit: op codes, FSM state codes,
// lane width and the saturation helper used by the lane multiplier.
package gpu_tensor_pkg;

    localparam int LANE_W_DEF = 16;
    localparam int WIDE_W     = 2 * LANE_W_DEF + 1;

    localparam logic [LANE_W_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [LANE_W_DEF-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        TOP_MUL = 2'd0,
        TOP_MAC = 2'd1,
        TOP_DOT = 2'd2,
        TOP_RSV = 2'd3
    } top_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Clamp a wide signed value into the signed lane range.
    function automatic logic [LANE_W_DEF-1:0] sat_lane(input logic signed [WIDE_W-1:0] v);
        if (v > WIDE_W'($signed(SAT_MAX)))
            return SAT_MAX;
        else if (v < WIDE_W'($signed(SAT_MIN)))
            return SAT_MIN;
        else
            return v[LANE_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/gpu_tensor_serial_unit_if.sv
// Tensor-issue bus between the core (master) and the serial tensor unit (slave).
interface gpu_tensor_serial_unit_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] in_c;
    logic              out_valid;
    logic [DATA_W-1:0] out_y;
    logic              busy;
    logic              err_drop;

    modport master (
        output in_valid, in_op, in_a, in_b, in_c,
        input  in_ready, out_valid, out_y, busy, err_drop
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_c,
        output in_ready, out_valid, out_y, busy, err_drop
    );
endinterface

// File: rtl/gpu_tensor_lane_mul.sv
// Combinational single-lane signed 16x16 multiplier with MUL and MAC results.
// Build option GPU_TENSOR_SAT_EN: MUL/MAC lane results saturate instead of wrapping.
module gpu_tensor_lane_mul
    import gpu_tensor_pkg::*;
(
    input  logic signed [LANE_W_DEF-1:0]   a,
    input  logic signed [LANE_W_DEF-1:0]   b,
    input  logic signed [LANE_W_DEF-1:0]   c,
    output logic signed [2*LANE_W_DEF-1:0] prod,
    output logic        [LANE_W_DEF-1:0]   mul_y,
    output logic        [LANE_W_DEF-1:0]   mac_y
);

    assign prod = a * b;

`ifdef GPU_TENSOR_SAT_EN
    logic signed [WIDE_W-1:0] mac_sum;

    // Full-width sum so the clamp sees the true value before narrowing.
    always_comb begin
        mac_sum = WIDE_W'(prod) + WIDE_W'(c);
        mul_y   = sat_lane(WIDE_W'(prod));
        mac_y   = sat_lane(mac_sum);
    end
`else
    // Wrapping results only need the low lane bits of product and sum.
    always_comb begin
        mul_y = prod[LANE_W_DEF-1:0];
        mac_y = prod[LANE_W_DEF-1:0] + c;
    end
`endif

endmodule

// File: rtl/gpu_tensor_serial_unit.sv
// Serial tensor unit: executes packed int16 MUL/MAC/DOT one lane per cycle on a
// single shared multiplier, returning a one-cycle out_valid LANES+1 cycles after issue.
// Build option GPU_TENSOR_SAT_EN: saturating MUL/MAC lanes (see gpu_tensor_lane_mul).
module gpu_tensor_serial_unit
    import gpu_tensor_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    gpu_tensor_serial_unit_if.slave  bus
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int ACC_W  = 64;
    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_e             state_q, state_d;
    logic               accept;
    logic               last_lane;
    logic [CNT_W-1:0]   cnt_q;
    top_e               op_q;
    logic [DATA_W-1:0]  a_q, b_q, c_q;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  out_y_q;
    logic [DATA_W-1:0]  result;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic               err_q;

    logic [LANE_W-1:0]          lane_a, lane_b, lane_c, lane_y;
    logic signed [2*LANE_W-1:0] prod;
    logic [LANE_W-1:0]          mul_y, mac_y;

    assign last_lane = (cnt_q == LAST_LANE);

    // Lane mux feeding the one shared multiplier.
    assign lane_a = a_q[int'(cnt_q)*LANE_W +: LANE_W];
    assign lane_b = b_q[int'(cnt_q)*LANE_W +: LANE_W];
    assign lane_c = c_q[int'(cnt_q)*LANE_W +: LANE_W];

    gpu_tensor_lane_mul u_lane_mul (
        .a     (lane_a),
        .b     (lane_b),
        .c     (lane_c),
        .prod  (prod),
        .mul_y (mul_y),
        .mac_y (mac_y)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and issue-accept decode; a new issue is taken in IDLE or DONE.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_lane)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-lane result select, shadow/accumulator update and final result pick.
    always_comb begin
        unique case (op_q)
            TOP_MUL: lane_y = mul_y;
            TOP_MAC: lane_y = mac_y;
            default: lane_y = '0;
        endcase

        shadow_d = shadow_q;
        shadow_d[int'(cnt_q)*LANE_W +: LANE_W] = lane_y;
        acc_d = acc_q + ACC_W'(prod);

        unique case (op_q)
            TOP_MUL, TOP_MAC: result = shadow_d;
            TOP_DOT:          result = DATA_W'(acc_d);
            default:          result = '0;
        endcase
    end

    // Operand capture, lane stepping, and result publish on the last lane.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: operand and shadow registers are reset too, so nothing stale leaks after an aborted op.
        if (rst) begin
            op_q     <= TOP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            acc_q    <= '0;
            out_y_q  <= '0;
        end else if (accept) begin
            op_q     <= top_e'(bus.in_op);
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            c_q      <= bus.in_c;
            cnt_q    <= '0;
            shadow_q <= '0;
            acc_q    <= '0;
        end else if (state_q == S_RUN) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            if (last_lane)
                out_y_q <= result;
        end
    end

    // Sticky flag for issues presented while the unit could not take them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (bus.in_valid && !bus.in_ready)
            err_q <= 1'b1;
    end

    assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_y     = out_y_q;
    assign bus.err_drop  = err_q;

endmodule

// File: tb/tb_gpu_tensor_serial_unit.sv
// Self-checking bench for gpu_tensor_serial_unit: directed vectors, latency,
// back-to-back issue, dropped issue, mid-op reset and randomized ops against a lane-level model.
module tb_gpu_tensor_serial_unit;

    logic        clk;
    logic        rst;
    int          compared;
    int          mismatched;
    logic [63:0] last_y;

    gpu_tensor_serial_unit_if #(.DATA_W(64)) bus ();

    gpu_tensor_serial_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane-level reference: each lane's product computed in plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] c);
        longint      ai, bi, ci, p, v, acc;
        logic [63:0] y;
        acc = 0;
        y   = '0;
        for (int i = 0; i < 4; i++) begin
            ai  = longint'($signed(a[16*i +: 16]));
            bi  = longint'($signed(b[16*i +: 16]));
            ci  = longint'($signed(c[16*i +: 16]));
            p   = ai * bi;
            acc = acc + p;
            v   = (op == 2'd1) ? p + ci : p;
`ifdef GPU_TENSOR_SAT_EN
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
`endif
            y[16*i +: 16] = 16'(v);
        end
        case (op)
            2'd0, 2'd1: return y;
            2'd2:       return 64'(acc);
            default:    return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 4))
                0:       v[16*i +: 16] = 16'h8000;
                1:       v[16*i +: 16] = 16'h7FFF;
                2:       v[16*i +: 16] = 16'hFFFF;
                default: v[16*i +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Issue one op from an idle unit, then check latency, held output and result.
    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] exp, input string tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_a     = {$urandom, $urandom};
            bus.in_b     = {$urandom, $urandom};
            bus.in_c     = {$urandom, $urandom};
            bus.in_op    = 2'($urandom);
            check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(k == 5));
            if (k < 5) check({tag, "_y_held"}, bus.out_y, last_y);
            else       check({tag, "_y"}, bus.out_y, exp);
        end
        last_y = exp;
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'h0);
        check({tag, "_idle"}, 64'(bus.busy), 64'h0);
    endtask

    initial begin
        logic [63:0] a1, b1, c1, a2, b2, c2, e1, e2;
        logic [1:0]  op1, op2;
        compared   = 0;
        mismatched = 0;
        last_y     = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op    = 2'd0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_c     = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_out_y", bus.out_y, 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_err_drop", 64'(bus.err_drop), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
`ifdef GPU_TENSOR_SAT_EN
        run_op(2'd0, 64'h7FFF_0064_FFFE_0003, 64'h0002_FFFD_0005_0004, 64'h0,
               64'h7FFF_FED4_FFF6_000C, "mul_vec");
        run_op(2'd1, 64'h0000_0000_FED4_03E8, 64'h0000_0000_00C8_03E8, 64'hFFFF_0007_FFFE_0005,
               64'hFFFF_0007_8000_7FFF, "mac_vec");
`else
        run_op(2'd0, 64'h7FFF_0064_FFFE_0003, 64'h0002_FFFD_0005_0004, 64'h0,
               64'hFFFE_FED4_FFF6_000C, "mul_vec");
        run_op(2'd1, 64'h0000_0000_FED4_03E8, 64'h0000_0000_00C8_03E8, 64'hFFFF_0007_FFFE_0005,
               64'hFFFF_0007_159E_4245, "mac_vec");
`endif
        run_op(2'd2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'hDEAD_BEEF_0000_1111,
               64'h0000_0000_0000_0046, "dot_small");
        run_op(2'd2, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 64'h0,
               64'h0000_0001_0000_0000, "dot_max");
        run_op(2'd3, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h1111_2222_3333_4444,
               64'h0, "op_rsv");

        // Back-to-back issue in the DONE cycle, plus a dropped issue during RUN.
        check("err_before_drop", 64'(bus.err_drop), 64'h0);
        op1 = 2'd1; a1 = rand_operand(); b1 = rand_operand(); c1 = rand_operand();
        op2 = 2'd0; a2 = rand_operand(); b2 = rand_operand(); c2 = rand_operand();
        e1 = model(op1, a1, b1, c1);
        e2 = model(op2, a2, b2, c2);
        bus.in_valid = 1'b1; bus.in_op = op1; bus.in_a = a1; bus.in_b = b1; bus.in_c = c1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("b2b_out_valid", 64'(bus.out_valid), 64'((k == 5) || (k == 10)));
            if (k < 5)       check("b2b_y_held0", bus.out_y, last_y);
            else if (k < 10) check("b2b_y_first", bus.out_y, e1);
            else             check("b2b_y_second", bus.out_y, e2);
            if (k == 5) begin
                check("b2b_ready_done", 64'(bus.in_ready), 64'h1);
                bus.in_valid = 1'b1; bus.in_op = op2; bus.in_a = a2; bus.in_b = b2; bus.in_c = c2;
            end
            if (k == 7) begin
                check("run_not_ready", 64'(bus.in_ready), 64'h0);
                check("err_still_clear", 64'(bus.err_drop), 64'h0);
                bus.in_valid = 1'b1; bus.in_op = 2'd2;
                bus.in_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.in_b = 64'h7FFF_7FFF_7FFF_7FFF;
            end
            if (k == 8) check("err_set", 64'(bus.err_drop), 64'h1);
        end
        last_y = e2;
        @(negedge clk);
        check("b2b_idle", 64'(bus.busy), 64'h0);
        check("err_sticky", 64'(bus.err_drop), 64'h1);

        // Reset two cycles into an op abandons it.
        bus.in_valid = 1'b1; bus.in_op = 2'd2;
        bus.in_a = rand_operand(); bus.in_b = rand_operand(); bus.in_c = rand_operand();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("mid_rst_out_y", bus.out_y, 64'h0);
        check("mid_rst_busy", 64'(bus.busy), 64'h0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("mid_rst_err_drop", 64'(bus.err_drop), 64'h0);
        last_y = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", 64'(bus.out_valid), 64'h0);
        end

        // Randomized ops against the model.
        for (int n = 0; n < 24; n++) begin
            op1 = 2'($urandom_range(0, 3));
            a1  = rand_operand();
            b1  = rand_operand();
            c1  = rand_operand();
            run_op(op1, a1, b1, c1, model(op1, a1, b1, c1), $sformatf("rand%0d_op%0d", n, op1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
